// File: rtl/rca_types_pkg.sv
// Shared types for the RCA writeback sequencer: packet layout, FSM states and
// the lowest-set-bit selector used to order register-file writes.
package rca_types;

    localparam int NUM_WRITE_PORTS = 5;
    localparam int XLEN            = 32;
    localparam int ID_W            = 3;
    localparam int PORT_IDX_W      = $clog2(NUM_WRITE_PORTS);

    typedef struct packed {
        logic [ID_W-1:0]                       id;
        logic [NUM_WRITE_PORTS-1:0][XLEN-1:0]  rd;
        logic [NUM_WRITE_PORTS-1:0][4:0]       dest_addr;
        logic [NUM_WRITE_PORTS-1:0]            mask;
    } rca_wb_packet_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } rca_wb_seq_state_t;

    // Lowest port wins so duplicate destinations retire in ascending port order.
    function automatic logic [PORT_IDX_W-1:0] lowest_set(input logic [NUM_WRITE_PORTS-1:0] m);
        lowest_set = '0;
        for (int i = NUM_WRITE_PORTS - 1; i >= 0; i--) begin
            if (m[i]) lowest_set = PORT_IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/rca_wb_fifo.sv
// Packet FIFO between the RCA writeback port and the serialising FSM.
// Pointers wrap modulo DEPTH; count carries one extra bit to tell full from empty.
module rca_wb_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q + AW'(push);
        rptr_d  = rptr_q + AW'(pop);
        count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr_q] <= din;
    end

    assign dout  = mem[rptr_q];
    assign count = count_q;
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/rca_wb_sequencer.sv
// Buffers multi-result RCA writeback packets and serialises them onto the single
// integer register-file write port, pulsing a commit when a packet's last write retires.
module rca_wb_sequencer
    import rca_types::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wb_done,
    input  logic [ID_W-1:0]                 wb_id,
    input  logic [NUM_WRITE_PORTS*XLEN-1:0] wb_rd,
    input  logic [NUM_WRITE_PORTS*5-1:0]    wb_dest_addr,
    input  logic [NUM_WRITE_PORTS-1:0]      wb_dest_valid,
    output logic                            wb_ready,
    output logic                            rf_we,
    output logic [4:0]                      rf_waddr,
    output logic [XLEN-1:0]                 rf_wdata,
    output logic                            commit_valid,
    output logic [ID_W-1:0]                 commit_id,
    output logic                            overflow,
    output logic                            busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rca_wb_packet_t             push_pkt, head_pkt, work_q, work_d;
    rca_wb_seq_state_t          state_q, state_d;
    logic                       push, pop, fifo_full, fifo_empty;
    logic [CW-1:0]              fifo_count;
    logic [PORT_IDX_W-1:0]      sel;
    logic [NUM_WRITE_PORTS-1:0] sel_onehot;
    logic                       rf_we_q, rf_we_d, commit_valid_q, commit_valid_d;
    logic                       overflow_q, overflow_d;
    logic [4:0]                 rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]            rf_wdata_q, rf_wdata_d;
    logic [ID_W-1:0]            commit_id_q, commit_id_d;

    // Ports writing x0 are dropped at push time so the drain never wastes a cycle on them.
    always_comb begin
        push_pkt.id = wb_id;
        for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
            push_pkt.rd[i]        = wb_rd[i*XLEN +: XLEN];
            push_pkt.dest_addr[i] = wb_dest_addr[i*5 +: 5];
            push_pkt.mask[i]      = wb_dest_valid[i] && (wb_dest_addr[i*5 +: 5] != 5'd0);
        end
    end

    assign push = wb_done && !fifo_full;

    rca_wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(rca_wb_packet_t))
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_pkt),
        .dout  (head_pkt),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign sel        = lowest_set(work_q.mask);
    assign sel_onehot = NUM_WRITE_PORTS'(1) << sel;

    always_comb begin
        pop            = 1'b0;
        state_d        = state_q;
        work_d         = work_q;
        rf_we_d        = 1'b0;
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        commit_valid_d = 1'b0;
        commit_id_d    = commit_id_q;
        overflow_d     = overflow_q | (wb_done & fifo_full);
        case (state_q)
            IDLE, LOAD: begin
                // An idle unit with a queued packet loads it immediately.
                if (!fifo_empty) begin
                    pop    = 1'b1;
                    work_d = head_pkt;
                    if (head_pkt.mask == '0) begin
                        commit_valid_d = 1'b1;
                        commit_id_d    = head_pkt.id;
                        state_d        = (fifo_count == CW'(1) && !push) ? IDLE : LOAD;
                    end else begin
                        state_d = DRAIN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                rf_we_d     = 1'b1;
                rf_waddr_d  = work_q.dest_addr[sel];
                rf_wdata_d  = work_q.rd[sel];
                work_d.mask = work_q.mask & ~sel_onehot;
                if ((work_q.mask & ~sel_onehot) == '0) begin
                    commit_valid_d = 1'b1;
                    commit_id_d    = work_q.id;
                    state_d        = (fifo_empty && !push) ? IDLE : LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            work_q         <= '0;
            rf_we_q        <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            commit_valid_q <= 1'b0;
            commit_id_q    <= '0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            work_q         <= work_d;
            rf_we_q        <= rf_we_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            commit_valid_q <= commit_valid_d;
            commit_id_q    <= commit_id_d;
            overflow_q     <= overflow_d;
        end
    end

    assign wb_ready     = !fifo_full;
    assign rf_we        = rf_we_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign commit_valid = commit_valid_q;
    assign commit_id    = commit_id_q;
    assign overflow     = overflow_q;
    assign busy         = !fifo_empty || (state_q != IDLE);

endmodule
